// File: rtl/axilite_read_addr_if.sv
// -----------------------------------------------------------------------------
// axilite_read_addr_if
//
// Bundles the AXI4-Lite read-address channel together with the head-of-queue
// view that the read-address front end hands to the read-data stage.
//
// Signals:
//   araddr        byte address from the AXI master
//   arprot        AXI protection bits
//   arvalid       address valid (master -> slave)
//   arready       address ready (slave -> master)
//   addr          head entry offset relative to the slave window
//   addr_good     head entry is present and legal
//   addr_err      head entry is present and illegal
//   deassert_addr consumer pop strobe for a good head entry
//   err_pop       consumer pop strobe for an error head entry
//
// Modports:
//   master  AXI master plus read-data stage (drives requests and pop strobes)
//   slave   the read-address front end itself
// -----------------------------------------------------------------------------
interface axilite_read_addr_if #(
  parameter int unsigned ADDR_SIZE = 32
);

  logic [ADDR_SIZE-1:0] araddr;
  logic [2:0]           arprot;
  logic                 arvalid;
  logic                 arready;

  logic [ADDR_SIZE-1:0] addr;
  logic                 addr_good;
  logic                 addr_err;
  logic                 deassert_addr;
  logic                 err_pop;

  modport master (
    output araddr,
    output arprot,
    output arvalid,
    input  arready,
    input  addr,
    input  addr_good,
    input  addr_err,
    output deassert_addr,
    output err_pop
  );

  modport slave (
    input  araddr,
    input  arprot,
    input  arvalid,
    output arready,
    output addr,
    output addr_good,
    output addr_err,
    input  deassert_addr,
    input  err_pop
  );

endinterface : axilite_read_addr_if

// File: rtl/axilite_read_addr.sv
// -----------------------------------------------------------------------------
// axilite_read_addr
//
// AXI4-Lite read-address channel front end. Every accepted AR handshake is
// classified (window, alignment, protection) and stored in a small in-order
// queue. The head entry is presented to the read-data stage as a
// window-relative byte offset qualified by addr_good / addr_err, and leaves
// the queue when the read-data stage signals that it has been consumed. With
// DEPTH >= 2 the master can issue a second read while the first is still
// being answered.
//
// Ports:
//   clk   clock, all logic on the rising edge
//   rst   synchronous active-high reset; empties the queue
//   bus   axilite_read_addr_if.slave
//           araddr/arprot/arvalid  -> AR request, sampled on arvalid & arready
//           arready                <- ~rst & queue not full (registered count)
//           addr                   <- head offset (araddr - BASE_ADDR), 0 if empty
//           addr_good / addr_err   <- head present and legal / illegal
//           deassert_addr          -> pops the head when addr_good
//           err_pop                -> pops the head when addr_err
//
// Parameters:
//   ADDR_SIZE     width of araddr and addr
//   DATA_WIDTH    bus data width; alignment unit is DATA_WIDTH/8 bytes
//   BASE_ADDR     first byte address of the slave window
//   WINDOW_BYTES  window size in bytes, multiple of DATA_WIDTH/8
//   DEPTH         queue depth, power of two, >= 2
//   REQUIRE_PRIV  1 = reads with arprot[0] = 0 are illegal
// -----------------------------------------------------------------------------
module axilite_read_addr #(
  parameter int unsigned          ADDR_SIZE    = 32,
  parameter int unsigned          DATA_WIDTH   = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR    = '0,
  parameter int unsigned          WINDOW_BYTES = 16,
  parameter int unsigned          DEPTH        = 2,
  parameter bit                   REQUIRE_PRIV = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  axilite_read_addr_if.slave  bus
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int unsigned PTR_W          = $clog2(DEPTH);
  localparam int unsigned CNT_W          = PTR_W + 1;

  // Low address bits that must be zero for an aligned access.
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK  = ADDR_SIZE'(BYTES_PER_BEAT - 1);
  // Largest offset at which a whole beat still fits inside the window.
  localparam logic [ADDR_SIZE-1:0] LAST_OFFSET = ADDR_SIZE'(WINDOW_BYTES - BYTES_PER_BEAT);
  localparam logic [CNT_W-1:0]     FULL_COUNT  = CNT_W'(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic [ADDR_SIZE-1:0] offset;
    logic                 illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Queue state
  // ---------------------------------------------------------------------------
  entry_t mem [DEPTH];
  ptr_t   wr_ptr;
  ptr_t   rd_ptr;
  cnt_t   count;
  cnt_t   count_nxt;

  logic   push;
  logic   pop;
  logic   empty;
  entry_t head;

  // ---------------------------------------------------------------------------
  // Request classification
  // ---------------------------------------------------------------------------
  logic [ADDR_SIZE-1:0] offset_in;
  logic                 below_base;
  logic                 past_window;
  logic                 misaligned;
  logic                 priv_fail;
  entry_t               entry_in;

  // The subtraction wraps modulo 2^ADDR_SIZE; the range test uses it only once
  // the address is known to be at or above the base, so a wrapped offset from
  // a below-base address can never be mistaken for an in-window one, and the
  // window end is never computed as BASE_ADDR + WINDOW_BYTES (which could
  // overflow at the top of the address map).
  assign offset_in   = bus.araddr - BASE_ADDR;
  assign below_base  = bus.araddr < BASE_ADDR;
  assign past_window = ~below_base & (offset_in > LAST_OFFSET);
  assign misaligned  = (bus.araddr & ALIGN_MASK) != '0;
  assign priv_fail   = REQUIRE_PRIV & ~bus.arprot[0];

  assign entry_in.offset  = offset_in;
  assign entry_in.illegal = below_base | past_window | misaligned | priv_fail;

  // Only the privileged bit of arprot affects legality.
  logic unused_prot;
  assign unused_prot = ^bus.arprot[2:1];

  // ---------------------------------------------------------------------------
  // Handshake and pop decode
  // ---------------------------------------------------------------------------
  // arready depends on the registered count (and reset) only, so there is no
  // combinational path from arvalid. A full queue refuses the push even when a
  // pop happens in the same cycle; arready rises on the next cycle instead.
  assign bus.arready = ~rst & (count != FULL_COUNT);
  assign push        = bus.arvalid & bus.arready;

  // A strobe only pops the head entry of its own kind; the other strobe is
  // ignored, so a stray deassert_addr cannot retire an error entry.
  assign pop = (bus.deassert_addr & bus.addr_good) |
               (bus.err_pop       & bus.addr_err);

  // ---------------------------------------------------------------------------
  // Head presentation (no bypass: a new entry shows up the cycle after push)
  // ---------------------------------------------------------------------------
  assign empty         = (count == '0);
  assign head          = mem[rd_ptr];
  assign bus.addr      = empty ? '0 : head.offset;
  assign bus.addr_good = ~empty & ~head.illegal;
  assign bus.addr_err  = ~empty &  head.illegal;

  // ---------------------------------------------------------------------------
  // Next count
  // ---------------------------------------------------------------------------
  // NOTE: count_nxt is given a value before the case so that every path through
  // the block assigns it; without that default synthesis would infer a latch.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;  // idle, or push and pop cancel out
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pointer and count registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so that
  // every register samples the pre-edge values of its neighbours, regardless
  // of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits wide and wrap on their own.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Entry storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately left out of reset. Its contents are
  // only observed through count, which is reset, so clearing it would add reset
  // fan-out to every bit for no functional gain.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

endmodule : axilite_read_addr

// File: doc/axilite_read_addr.md
Name: axilite_read_addr

Overview:
AXI4-Lite read-address (AR) channel front end that feeds the read-data stage. Accepts AR handshakes into a small in-order queue and checks each address for window, alignment and protection. Presents the head entry as a window-relative byte offset with addr_good/addr_err qualifiers, and pops it when the read-data stage signals consumption. Lets the master issue a second read while the first is still being answered.

Parameters:
ADDR_SIZE, 32, width of araddr and of the addr offset output
DATA_WIDTH, 32, bus data width in bits; alignment unit is DATA_WIDTH/8 bytes
BASE_ADDR, 32'h0000_0000, first byte address of this slave's window
WINDOW_BYTES, 16, window size in bytes; must be a multiple of DATA_WIDTH/8 (16 = 4 words of 32 bits)
DEPTH, 2, queue depth in entries; power of two, >= 2
REQUIRE_PRIV, 0, 1 = reject reads with arprot[0]=0

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
araddr  input  ADDR_SIZE  AXI read address (byte address)
arprot  input  3  AXI protection bits
arvalid  input  1  AXI address valid
arready  output  1  AXI address ready
addr  output  ADDR_SIZE  head entry offset = araddr - BASE_ADDR; 0 when queue empty
addr_good  output  1  head entry valid and legal
addr_err  output  1  head entry valid and illegal
deassert_addr  input  1  consumer pop strobe for a good entry
err_pop  input  1  consumer pop strobe for an error entry

Behaviour:
- Reset (sampled on clk while rst=1): queue emptied, read/write pointers and count = 0; arready=0, addr=0, addr_good=0, addr_err=0. arready stays 0 the whole time rst is high.
- arready = ~rst & (count != DEPTH). It is a function of registered count only and has no combinational path from arvalid.
- Push on the cycle where arvalid & arready. The entry stores {offset, illegal}:
  - offset = araddr - BASE_ADDR, computed modulo 2^ADDR_SIZE.
  - illegal = (araddr < BASE_ADDR) | (araddr - BASE_ADDR > WINDOW_BYTES - DATA_WIDTH/8) | (araddr mod DATA_WIDTH/8 != 0) | (REQUIRE_PRIV & ~arprot[0]).
  - The range check must not overflow: compare after subtraction, and only once araddr >= BASE_ADDR is known.
- Latency: a pushed entry becomes visible on addr/addr_good/addr_err on the cycle after the handshake. There is no same-cycle bypass.
- Outputs come from the head entry only, strictly in order:
  - addr_good = ~empty & ~illegal
  - addr_err = ~empty & illegal
  - addr_good and addr_err are never both 1.
- Pop when (deassert_addr & addr_good) | (err_pop & addr_err).
  - deassert_addr is ignored while addr_good=0.
  - err_pop is ignored while addr_err=0.
- Simultaneous push and pop:
  - count 0: push only, since pop is impossible.
  - 0 < count < DEPTH: count unchanged; head advances to the next entry (the new entry if count was 1).
  - count = DEPTH: arready=0, so pop only; arready rises the following cycle.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Holding rules:
  - While arvalid=1 and arready=0, araddr is not sampled. The master holds it per AXI.
  - A head entry stays stable, with addr unchanged, until popped.
- Reset mid-operation: all queued entries are discarded with no pops reported. addr_good/addr_err drop to 0 on the cycle after rst is sampled high.
- Entry storage needs no reset; only valid/count/pointers are reset.

Test Plan:
1. Single legal read: BASE=0x4000_0000, WINDOW 16, push araddr=0x4000_0008 -> next cycle addr=0x8, addr_good=1; deassert_addr pulse -> addr_good=0 next cycle, count 0.
2. Illegal addresses: 0x4000_0010 (past window), 0x4000_0006 (misaligned), 0x3FFF_FFFC (below base) -> each gives addr_err=1, addr_good=0; err_pop clears each; deassert_addr while addr_err=1 does not pop.
3. Fill and backpressure: push 0x4000_0000 then 0x4000_0004 with no pops -> arready=0 after second push; third arvalid held for 5 cycles is not accepted; one deassert_addr -> addr=0x4, arready=1 next cycle, third address accepted.
4. Simultaneous push+pop at count 1: head 0x0 popped while 0x4000_000C is pushed -> count stays 1, addr=0xC next cycle; order preserved over 20 random mixed legal/illegal pushes against a scoreboard.
5. REQUIRE_PRIV=1: araddr 0x4000_0004 with arprot=3'b000 -> addr_err=1; with arprot=3'b001 -> addr_good=1.
6. Reset with 2 entries queued -> arready=0 while rst=1, queue empty and all outputs 0 after; first push after reset appears with 1-cycle latency.
